msk_rnd_src: RTL and testbench
==============================

Name: msk_rnd_src

Overview:
- Randomness source feeding the `rnd` inputs of masked gadgets such as the SNI refresh; sits directly upstream of them.
- 64-bit LFSR PRNG, unrolled to emit N_RND fresh bits per cycle.
- Seed is loaded over a valid/ready port; output uses a valid/ready handshake.
- Lifecycle FSM: unseeded, seeding, warm-up, running. Mid-run reseed supported.

Parameters:
- N_RND, 8, output bits per step (set to the consumer's ref_n_rnd); legal range 1..64.
- WARMUP, 16, discarded steps after seeding; legal range 1..255.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- seed_in  in  32  seed word.
- seed_valid  in  1  seed word present.
- seed_ready  out  1  block accepts a seed word this cycle.
- reseed  in  1  single-cycle pulse; discard state and request a new seed.
- rnd_out  out  N_RND  random bits.
- rnd_valid  out  1  rnd_out usable.
- rnd_ready  in  1  consumer takes rnd_out this cycle.
- busy  out  1  high in any state other than RUN.

Behaviour:
- Reset: one clock; reset is synchronous and active-low.
  - Sampled rst_n=0 gives state=UNSEEDED, lfsr=0, seed_ready=0, rnd_valid=0, rnd_out=0, busy=1, warm-up counter=0.
  - Reset mid-operation aborts everything identically.
- LFSR: 64-bit Fibonacci, taps x^64+x^63+x^61+x^60+1.
  - One step = N_RND single-bit shifts unrolled combinationally.
  - The N_RND bits shifted in, oldest in bit 0, form the next rnd_out.
- UNSEEDED:
  - seed_ready=1.
  - Handshake (seed_valid&&seed_ready) loads seed_in into lfsr[31:0], then goes to SEED_HI.
- SEED_HI:
  - seed_ready=1.
  - Handshake loads lfsr[63:32], then goes to WARM.
  - If the full 64-bit value is zero, lfsr loads 64'h0000_0000_0000_0001 instead (lock-up guard).
- WARM:
  - seed_ready=0.
  - Steps the LFSR every cycle; the counter increments each step.
  - After WARMUP steps, goes to RUN; rnd_out is preloaded with the last step's bits.
- RUN:
  - rnd_valid=1 and busy=0.
  - On rnd_valid&&rnd_ready, the LFSR steps and rnd_out takes the new bits on the next edge.
  - Without rnd_ready, rnd_out holds stable.
  - With rnd_ready tied high, a new word is produced every cycle (zero-bubble).
- Output latency: first rnd_valid appears WARMUP+1 cycles after the second seed handshake.
- reseed:
  - From any state, the next cycle enters UNSEEDED with lfsr cleared and rnd_valid=0.
  - rnd_out is zeroed so stale randomness cannot be reused.
  - reseed coinciding with a seed handshake: reseed wins and the word is dropped.
  - reseed coinciding with an output handshake: the output transfer counts, but no new word is produced.
- seed_valid outside UNSEEDED/SEED_HI is ignored.
- rnd_ready while rnd_valid=0 is ignored.
- No combinational path from any input to rnd_out. rnd_valid and seed_ready are decoded from registered state only.

Optional Feature:
- Macro: MSK_RND_SRC_CNT_EN.
- When defined:
  - Extra output port rnd_count, 32-bit.
  - Counts completed output handshakes; saturates at 32'hFFFF_FFFF.
  - Cleared by reset and by reseed.
  - Used by benches to check randomness consumption against a gadget's fv_rnd_count.
- When undefined: the port and counter are absent, with no other behavioural difference.

Decomposition:
- Package msk_rnd_pkg holds:
  - FSM state enum {UNSEEDED, SEED_HI, WARM, RUN};
  - LFSR width constant 64;
  - tap mask constant;
  - zero-seed substitute constant.
- Sub-module msk_lfsr_step: purely combinational N_RND-step unroll.
  - Inputs: state.
  - Outputs: next state and N_RND bits.
  - Reused by other randomness sources.

Test Plan:
- Reset then seeds 32'h0000_0001 / 32'h0000_0000 with rnd_ready=1, WARMUP=16, N_RND=8 -> rnd_valid rises exactly 17 cycles after the second seed handshake; outputs match the bench's software LFSR model for 1000 words.
- Both seed words zero -> lfsr equals 64'h1 after loading; outputs equal the scenario-1 sequence.
- rnd_ready toggled 1,0,0,1 in RUN -> rnd_out holds across the low cycles; exactly 2 words consumed; no word skipped or repeated against the model.
- reseed pulse in RUN, same cycle as rnd_ready=1 -> next cycle rnd_valid=0, rnd_out=0, seed_ready=1, busy=1; re-seeding with identical words reproduces the original sequence from word 0.
- rst_n=0 asserted for one cycle in WARM -> all outputs at reset values next cycle; seed_valid held high in WARM is ignored and no lfsr change comes from seed_in.
- With MSK_RND_SRC_CNT_EN: 5 output handshakes then reseed -> rnd_count reads 5, then 0; forced preload to 32'hFFFF_FFFE plus 3 handshakes -> 32'hFFFF_FFFF.

Source files
------------

// File: rtl/msk_rnd_pkg.sv
// msk_rnd_pkg: shared types and constants for the masking randomness sources.
package msk_rnd_pkg;
  localparam int LFSR_W = 64;
  // Feedback taps for x^64+x^63+x^61+x^60+1 on a left-shifting register.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
  localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 64'h0000_0000_0000_0001;
  typedef enum logic [1:0] {UNSEEDED, SEED_HI, WARM, RUN} rnd_state_e;
endpackage

// File: rtl/msk_lfsr_step.sv
// msk_lfsr_step: combinational N_RND-shift unroll of the 64-bit Fibonacci LFSR.
module msk_lfsr_step
  import msk_rnd_pkg::*;
#(
  parameter int N_RND = 8
) (
  input  logic [LFSR_W-1:0] state_i,
  output logic [LFSR_W-1:0] next_o,
  output logic [N_RND-1:0]  bits_o
);
  always_comb begin
    next_o = state_i;
    bits_o = '0;
    for (int i = 0; i < N_RND; i++) begin
      bits_o[i] = ^(next_o & LFSR_TAPS);
      next_o = {next_o[LFSR_W-2:0], bits_o[i]};
    end
  end
endmodule

// File: rtl/msk_rnd_src.sv
// msk_rnd_src: seeded LFSR randomness source with valid/ready output.
// Define MSK_RND_SRC_CNT_EN to add the saturating rnd_count handshake counter.
module msk_rnd_src
  import msk_rnd_pkg::*;
#(
  parameter int N_RND  = 8,
  parameter int WARMUP = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      seed_in,
  input  logic             seed_valid,
  output logic             seed_ready,
  input  logic             reseed,
  output logic [N_RND-1:0] rnd_out,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic             busy
`ifdef MSK_RND_SRC_CNT_EN
  ,
  output logic [31:0]      rnd_count
`endif
);
  rnd_state_e state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, step_next, seed_full;
  logic [N_RND-1:0] rnd_q, rnd_d, step_bits;
  logic [7:0] warm_q, warm_d;
  logic armed_q;
  logic seed_hs, out_hs;

  msk_lfsr_step #(.N_RND(N_RND)) u_step (
    .state_i(lfsr_q),
    .next_o (step_next),
    .bits_o (step_bits)
  );

  // Seed port opens one cycle after reset so reset itself shows seed_ready=0.
  assign seed_ready = armed_q && (state_q == UNSEEDED || state_q == SEED_HI);
  assign rnd_valid  = state_q == RUN;
  assign busy       = state_q != RUN;
  assign rnd_out    = rnd_q;
  assign seed_hs    = seed_valid && seed_ready;
  assign out_hs     = rnd_valid && rnd_ready;
  assign seed_full  = {seed_in, lfsr_q[31:0]};

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    rnd_d   = rnd_q;
    warm_d  = warm_q;
    if (reseed) begin
      state_d = UNSEEDED;
      lfsr_d  = '0;
      rnd_d   = '0;
      warm_d  = '0;
    end else begin
      case (state_q)
        UNSEEDED: if (seed_hs) begin
          lfsr_d[31:0] = seed_in;
          state_d      = SEED_HI;
        end
        SEED_HI: if (seed_hs) begin
          lfsr_d  = (seed_full == '0) ? ZERO_SEED_SUB : seed_full;
          warm_d  = '0;
          state_d = WARM;
        end
        WARM: begin
          lfsr_d = step_next;
          warm_d = warm_q + 8'd1;
          if (warm_q == 8'(WARMUP - 1)) begin
            state_d = RUN;
            rnd_d   = step_bits;
          end
        end
        RUN: if (out_hs) begin
          lfsr_d = step_next;
          rnd_d  = step_bits;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= UNSEEDED;
      lfsr_q  <= '0;
      rnd_q   <= '0;
      warm_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      rnd_q   <= rnd_d;
      warm_q  <= warm_d;
      armed_q <= 1'b1;
    end
  end

`ifdef MSK_RND_SRC_CNT_EN
  logic [31:0] cnt_q, cnt_d;
  assign cnt_d     = reseed ? '0 : (out_hs && cnt_q != '1) ? cnt_q + 32'd1 : cnt_q;
  assign rnd_count = cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`endif
endmodule

// File: tb/tb_msk_rnd_src.sv
// tb_msk_rnd_src: randomized bench for msk_rnd_src against a software LFSR model.
module tb_msk_rnd_src;
  localparam int N  = 8;
  localparam int WU = 16;

  logic clk = 1'b0, rst_n = 1'b0, seed_valid = 1'b0, reseed = 1'b0, rnd_ready = 1'b0;
  logic [31:0] seed_in = '0;
  logic seed_ready, rnd_valid, busy;
  logic [N-1:0] rnd_out;
`ifdef MSK_RND_SRC_CNT_EN
  logic [31:0] rnd_count;
`endif
  int n_cmp = 0, n_bad = 0;

  int m_ph = 0, m_warm = 0, m_w = 0;
  logic m_armed = 1'b0;
  logic [31:0] m_lo = '0, m_cnt = '0;
  logic [63:0] m_seed = '0;

  always #5 clk = ~clk;

  msk_rnd_src #(.N_RND(N), .WARMUP(WU)) dut (
    .clk(clk), .rst_n(rst_n), .seed_in(seed_in), .seed_valid(seed_valid),
    .seed_ready(seed_ready), .reseed(reseed), .rnd_out(rnd_out),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .busy(busy)
`ifdef MSK_RND_SRC_CNT_EN
    , .rnd_count(rnd_count)
`endif
  );

  // Word k of the raw stream: the N bits fed back during the (k+1)-th step from seed.
  function automatic logic [N-1:0] raw_word(input logic [63:0] seed, input int k);
    logic [63:0] s = seed;
    logic [N-1:0] w = '0;
    logic b;
    for (int j = 0; j <= k; j++)
      for (int i = 0; i < N; i++) begin
        b = s[63] ^ s[62] ^ s[60] ^ s[59];
        w[i] = b;
        s = {s[62:0], b};
      end
    return w;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lifecycle model driven purely by the applied inputs.
  initial forever begin
    logic sr, vld;
    @(posedge clk);
    sr  = m_armed && m_ph < 2;
    vld = m_ph == 3;
    if (!rst_n) begin
      m_ph = 0; m_w = 0; m_armed = 1'b0; m_cnt = '0; m_seed = '0;
    end else begin
      m_armed = 1'b1;
      if (reseed) begin
        m_ph = 0; m_w = 0; m_cnt = '0;
      end else if (m_ph == 0) begin
        if (seed_valid && sr) begin m_lo = seed_in; m_ph = 1; end
      end else if (m_ph == 1) begin
        if (seed_valid && sr) begin
          m_seed = {seed_in, m_lo};
          if (m_seed == '0) m_seed = 64'h1;
          m_warm = WU;
          m_ph = 2;
        end
      end else if (m_ph == 2) begin
        m_warm--;
        if (m_warm == 0) begin m_ph = 3; m_w = 0; end
      end else if (vld && rnd_ready) begin
        m_w++;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("seed_ready", seed_ready, m_armed && m_ph < 2);
    chk("rnd_valid", rnd_valid, m_ph == 3);
    chk("busy", busy, m_ph != 3);
    chk("rnd_out", rnd_out, (m_ph == 3) ? raw_word(m_seed, WU - 1 + m_w) : '0);
`ifdef MSK_RND_SRC_CNT_EN
    chk("rnd_count", rnd_count, m_cnt);
`endif
  end

  task automatic seed(input logic [31:0] lo, input logic [31:0] hi, input logic hold);
    int n = 0;
    seed_valid = 1'b1;
    seed_in = lo;
    while (!seed_ready && n < 8) begin tick(); n++; end
    chk("seed_rdy_lo", seed_ready, 1);
    tick();
    seed_in = hi;
    chk("seed_rdy_hi", seed_ready, 1);
    tick();
    seed_valid = hold;
    seed_in = $urandom;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!rnd_valid && n < 300) begin tick(); n++; end
    chk("valid_timeout", rnd_valid, 1);
  endtask

  task automatic chk_idle(input string nm, input logic sr);
    chk({nm, "_valid"}, rnd_valid, 0);
    chk({nm, "_out"}, rnd_out, 0);
    chk({nm, "_seed_ready"}, seed_ready, sr);
    chk({nm, "_busy"}, busy, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, ws;
    logic [N-1:0] o1;
    chk("pin_w6", raw_word(64'h1, 6), 8'h00);
    chk("pin_w7", raw_word(64'h1, 7), 8'hD8);
    tick();
    rst_n = 1'b1;
    chk_idle("reset", 1'b0);
    tick();
    chk("armed", seed_ready, 1);

    rnd_ready = 1'b1;
    seed(32'h0000_0001, 32'h0000_0000, 1'b0);
    wait_valid(n);
    chk("latency", n + 1, WU + 1);
    chk("s1_first", rnd_out, raw_word(64'h1, WU - 1));
    repeat (1000) tick();

    reseed = 1'b1; tick(); reseed = 1'b0;
    seed(32'h0, 32'h0, 1'b0);
    chk("zero_guard", dut.lfsr_q, 64'h1);
    wait_valid(n);
    chk("s2_first", rnd_out, raw_word(64'h1, WU - 1));
    repeat (20) tick();

    rnd_ready = 1'b0; tick();
    ws = m_w;
    rnd_ready = 1'b1; tick();
    o1 = rnd_out;
    chk("tog_first", o1, raw_word(64'h1, WU + ws));
    rnd_ready = 1'b0; tick();
    chk("hold1", rnd_out, o1);
    tick();
    chk("hold2", rnd_out, o1);
    rnd_ready = 1'b1; tick();
    chk("tog_second", rnd_out, raw_word(64'h1, WU + ws + 1));

    reseed = 1'b1; tick(); reseed = 1'b0;
    chk_idle("reseed", 1'b1);
    seed(32'h0000_0001, 32'h0000_0000, 1'b0);
    wait_valid(n);
    chk("reseed_first", rnd_out, raw_word(64'h1, WU - 1));
    repeat (10) tick();

    reseed = 1'b1; tick(); reseed = 1'b0;
    seed(32'h0000_0001, 32'h0000_0000, 1'b1);
    wait_valid(n);
    chk("held_seed_first", rnd_out, raw_word(64'h1, WU - 1));
    seed_valid = 1'b0;

    reseed = 1'b1; tick(); reseed = 1'b0;
    seed(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    repeat (5) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    seed_valid = 1'b0;
    chk_idle("warm_reset", 1'b0);

    repeat (2000) begin
      rnd_ready  = $urandom_range(0, 1) == 1;
      seed_valid = $urandom_range(0, 3) != 0;
      seed_in    = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      reseed     = $urandom_range(0, 149) == 0;
      rst_n      = $urandom_range(0, 499) != 0;
      tick();
    end
    rst_n = 1'b1; reseed = 1'b0; seed_valid = 1'b0; rnd_ready = 1'b0;

`ifdef MSK_RND_SRC_CNT_EN
    reseed = 1'b1; tick(); reseed = 1'b0;
    seed(32'h5, 32'h7, 1'b0);
    wait_valid(n);
    rnd_ready = 1'b1; repeat (5) tick(); rnd_ready = 1'b0;
    chk("cnt5", rnd_count, 5);
    reseed = 1'b1; tick(); reseed = 1'b0;
    chk("cnt0", rnd_count, 0);
    seed(32'h5, 32'h7, 1'b0);
    wait_valid(n);
    force dut.cnt_q = 32'hFFFF_FFFE;
    release dut.cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    rnd_ready = 1'b1; repeat (3) tick(); rnd_ready = 1'b0;
    chk("cnt_sat", rnd_count, 32'hFFFF_FFFF);
`endif
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
